// File: rtl/rv_pkg.sv
// ---------------------------------------------------------------------------
// rv_pkg
//   Shared types and constants for the RV32I pipeline front end.
//
//   Contents:
//     DEFAULT_RESET_PC  : PC loaded when the core leaves reset
//     DEFAULT_NOP_INSTR : bubble encoding, addi x0,x0,0
//     fetch_state_t     : fetch sequencer states
//     if_id_t           : contents of the IF/ID pipeline register
//     align_word()      : clears the byte-offset bits of an address
//     bubble_entry()    : builds an IF/ID entry that carries no instruction
// ---------------------------------------------------------------------------
package rv_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

  // FETCH    : a request for PC_F is on the instruction-memory port
  // BUFFERED : a returned word waits in the skid buffer for decode
  // DISCARD  : the outstanding request belongs to a squashed path
  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    BUFFERED = 2'd1,
    DISCARD  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  // Instructions are word aligned, so redirect targets drop bits [1:0].
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // A bubble carries the NOP encoding and zeroed PC fields so that decode
  // sees a harmless instruction even if it ignores the valid bit.
  function automatic if_id_t bubble_entry(input logic [31:0] nop_instr);
    if_id_t entry;
    entry.pc      = 32'h0000_0000;
    entry.pcplus4 = 32'h0000_0000;
    entry.instr   = nop_instr;
    entry.valid   = 1'b0;
    return entry;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg
//   IF/ID pipeline register. Holds one if_id_t entry for the decode stage.
//
//   Ports:
//     clk     in   system clock, rising edge
//     rst_n   in   synchronous active-low reset, loads a bubble
//     en      in   1 = load d this cycle, 0 = hold
//     bubble  in   1 = load a bubble this cycle (wins over en)
//     d       in   next entry
//     q       out  current entry
// ---------------------------------------------------------------------------
module if_id_reg
  import rv_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  input  logic   bubble,
  input  if_id_t d,
  output if_id_t q
);

  // The bubble request wins over the enable so that a flush still squashes
  // the register while decode is otherwise holding its contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= bubble_entry(NOP_INSTR);
    end else if (bubble) begin
      q <= bubble_entry(NOP_INSTR);
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch front end of the 5-stage RV32I pipeline. Owns PC_F,
//   the instruction-memory request handshake, a one-entry skid buffer and
//   the IF/ID pipeline register.
//
//   Ports:
//     clk         in   system clock, rising edge
//     rst_n       in   synchronous active-low reset
//     Stall_F     in   1 = PC may advance, 0 = hold
//     Stall_D     in   1 = IF/ID may load, 0 = hold
//     Flush_D     in   1 = IF/ID loads a bubble this cycle
//     PCSrc_E     in   1 = taken branch/jump in EX, redirect fetch
//     PCTarget_E  in   redirect target (bits [1:0] ignored)
//     imem_req    out  instruction-memory request
//     imem_addr   out  request address, always PC_F
//     imem_ready  in   response valid this cycle (may be zero-wait)
//     imem_rdata  in   instruction word, valid with imem_ready
//     PC_D        out  IF/ID PC
//     PCPlus4_D   out  IF/ID PC+4
//     Instr_D     out  IF/ID instruction
//     Valid_D     out  IF/ID holds a real instruction
// ---------------------------------------------------------------------------
module fetch_stage
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Stall_F,
  input  logic        Stall_D,
  input  logic        Flush_D,
  input  logic        PCSrc_E,
  input  logic [31:0] PCTarget_E,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_D,
  output logic [31:0] PCPlus4_D,
  output logic [31:0] Instr_D,
  output logic        Valid_D
);

  fetch_state_t state;
  logic [31:0]  pc_f;
  logic [31:0]  pc_f_plus4;
  logic [31:0]  redirect_pc;
  logic [31:0]  discard_pc;
  logic [31:0]  skid_pc;
  logic [31:0]  skid_instr;
  logic         req_q;

  if_id_t       if_id_d;
  if_id_t       if_id_q;
  logic         if_id_en;
  logic         if_id_bubble;
  logic         deliver;

  // PC+4 wraps naturally in 32 bits, so 0xFFFF_FFFC rolls over to zero.
  assign pc_f_plus4  = pc_f + 32'd4;
  assign redirect_pc = align_word(PCTarget_E);

  // The address is the PC register itself. PC_F only moves on a response or
  // while no request is outstanding, so the address never changes mid-request.
  assign imem_req  = req_q;
  assign imem_addr = pc_f;

  // Decide what IF/ID sees this cycle. A real instruction is offered either
  // straight from memory (FETCH with a response) or from the skid buffer
  // (BUFFERED). A redirect squashes whatever is on offer, and DISCARD never
  // offers anything because its response belongs to the wrong path. When
  // decode is enabled but nothing is on offer, a bubble is loaded instead.
  always_comb begin
    deliver = 1'b0;
    if_id_d = '{pc: pc_f, pcplus4: pc_f_plus4, instr: imem_rdata, valid: 1'b1};
    case (state)
      FETCH: begin
        deliver = imem_ready && !PCSrc_E;
      end
      BUFFERED: begin
        deliver = !PCSrc_E;
        if_id_d = '{pc: skid_pc, pcplus4: skid_pc + 32'd4, instr: skid_instr,
                    valid: 1'b1};
      end
      default: begin
        deliver = 1'b0;
      end
    endcase
    if_id_en     = Stall_D;
    if_id_bubble = Flush_D || (Stall_D && !deliver);
  end

  // Fetch sequencer: owns PC_F, the request flag, the skid buffer and the
  // latched redirect target.
  //  - A response that decode cannot take is parked in the skid buffer and
  //    the request is withdrawn until decode drains it.
  //  - A response squashed by Flush_D does not advance the PC, so the same
  //    address is simply fetched again.
  //  - A redirect that arrives while a request is still in flight cannot
  //    move the address, so the target is remembered and the stale response
  //    is thrown away in DISCARD. Newer redirects replace the remembered one.
  //  - Redirects take effect regardless of Stall_F.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc_f       <= RESET_PC;
      req_q      <= 1'b1;
      discard_pc <= 32'h0000_0000;
      skid_pc    <= 32'h0000_0000;
      skid_instr <= NOP_INSTR;
    end else begin
      case (state)
        FETCH: begin
          if (PCSrc_E) begin
            if (imem_ready) begin
              pc_f <= redirect_pc;
            end else begin
              discard_pc <= redirect_pc;
              state      <= DISCARD;
            end
          end else if (imem_ready && !Flush_D) begin
            if (Stall_D) begin
              if (Stall_F) begin
                pc_f <= pc_f_plus4;
              end
            end else begin
              skid_pc    <= pc_f;
              skid_instr <= imem_rdata;
              state      <= BUFFERED;
              req_q      <= 1'b0;
            end
          end
        end

        BUFFERED: begin
          if (PCSrc_E) begin
            pc_f  <= redirect_pc;
            state <= FETCH;
            req_q <= 1'b1;
          end else if (Flush_D) begin
            state <= FETCH;
            req_q <= 1'b1;
          end else if (Stall_D) begin
            if (Stall_F) begin
              pc_f <= pc_f_plus4;
            end
            state <= FETCH;
            req_q <= 1'b1;
          end
        end

        DISCARD: begin
          if (imem_ready) begin
            pc_f  <= PCSrc_E ? redirect_pc : discard_pc;
            state <= FETCH;
          end else if (PCSrc_E) begin
            discard_pc <= redirect_pc;
          end
        end

        default: begin
          state <= FETCH;
          req_q <= 1'b1;
        end
      endcase
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (if_id_en),
    .bubble (if_id_bubble),
    .d      (if_id_d),
    .q      (if_id_q)
  );

  assign PC_D      = if_id_q.pc;
  assign PCPlus4_D = if_id_q.pcplus4;
  assign Instr_D   = if_id_q.instr;
  assign Valid_D   = if_id_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//   Self-checking bench for fetch_stage. Memory returns addr ^ 32'hA5A5_0000.
//   A behavioural model tracks the fetch address, at most one held
//   instruction and a pending squash, and predicts the IF/ID contents.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_f;
  logic        stall_d;
  logic        flush_d;
  logic        pcsrc_e;
  logic [31:0] pctarget_e;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc_d;
  logic [31:0] pcplus4_d;
  logic [31:0] instr_d;
  logic        valid_d;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state
  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } held_t;

  held_t       held_q[$];
  logic [31:0] m_pc;
  bit          m_squash;
  logic [31:0] m_squash_pc;
  bit          e_valid;
  logic [31:0] e_pc;
  logic [31:0] e_pc4;
  logic [31:0] e_instr;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Stall_F    (stall_f),
    .Stall_D    (stall_d),
    .Flush_D    (flush_d),
    .PCSrc_E    (pcsrc_e),
    .PCTarget_E (pctarget_e),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .PC_D       (pc_d),
    .PCPlus4_D  (pcplus4_d),
    .Instr_D    (instr_d),
    .Valid_D    (valid_d)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Fetch-stream reference: one instruction may be waiting for decode, and a
  // redirect seen while memory is busy makes the next response worthless.
  task automatic modelStep();
    logic [31:0] tgt;
    bit          dlv;
    logic [31:0] dpc;
    logic [31:0] dword;
    if (!rst_n) begin
      held_q.delete();
      m_pc     = 32'h0;
      m_squash = 0;
      e_valid  = 0;
      e_pc     = 32'h0;
      e_pc4    = 32'h0;
      e_instr  = NOP;
      return;
    end
    tgt   = pctarget_e & 32'hFFFF_FFFC;
    dlv   = 0;
    dpc   = 32'h0;
    dword = 32'h0;
    if (m_squash) begin
      if (pcsrc_e) m_squash_pc = tgt;
      if (imem_ready) begin
        m_pc     = m_squash_pc;
        m_squash = 0;
      end
    end else if (held_q.size() != 0) begin
      if (pcsrc_e) begin
        held_q.delete();
        m_pc = tgt;
      end else if (flush_d) begin
        held_q.delete();
      end else if (stall_d) begin
        dlv   = 1;
        dpc   = held_q[0].pc;
        dword = held_q[0].word;
        held_q.delete();
        if (stall_f) m_pc = m_pc + 32'd4;
      end
    end else if (imem_ready) begin
      if (pcsrc_e) begin
        m_pc = tgt;
      end else if (!flush_d) begin
        if (stall_d) begin
          dlv   = 1;
          dpc   = m_pc;
          dword = m_pc ^ KEY;
          if (stall_f) m_pc = m_pc + 32'd4;
        end else begin
          held_q.push_back('{pc: m_pc, word: m_pc ^ KEY});
        end
      end
    end else if (pcsrc_e) begin
      m_squash    = 1;
      m_squash_pc = tgt;
    end
    if (flush_d || (stall_d && !dlv)) begin
      e_valid = 0;
      e_instr = NOP;
    end else if (stall_d) begin
      e_valid = 1;
      e_pc    = dpc;
      e_pc4   = dpc + 32'd4;
      e_instr = dword;
    end
  endtask

  task automatic compareModel();
    checkOutput("Valid_D", {31'b0, valid_d}, {31'b0, e_valid});
    checkOutput("Instr_D", instr_d, e_instr);
    if (e_valid) begin
      checkOutput("PC_D", pc_d, e_pc);
      checkOutput("PCPlus4_D", pcplus4_d, e_pc4);
    end
    checkOutput("imem_req", {31'b0, imem_req}, {31'b0, held_q.size() == 0});
    checkOutput("imem_addr", imem_addr, m_pc);
  endtask

  // Drives one cycle of inputs at the falling edge, lets the rising edge
  // happen, then compares at the next falling edge.
  task automatic applyStimulus(input bit rst_v, input bit sf, input bit sd,
                               input bit fl, input bit ps,
                               input logic [31:0] tgt, input bit rdy);
    rst_n      = rst_v;
    stall_f    = sf;
    stall_d    = sd;
    flush_d    = fl;
    pcsrc_e    = ps;
    pctarget_e = tgt;
    imem_ready = rdy;
    imem_rdata = rdy ? (imem_addr ^ KEY) : $urandom();
    modelStep();
    @(posedge clk);
    @(negedge clk);
    compareModel();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 0; stall_f = 1; stall_d = 1; flush_d = 0; pcsrc_e = 0;
    pctarget_e = 0; imem_ready = 0; imem_rdata = 0;
    held_q.delete();
    m_pc = 0; m_squash = 0; m_squash_pc = 0;
    e_valid = 0; e_pc = 0; e_pc4 = 0; e_instr = NOP;
    @(negedge clk);

    $display("[TB] reset");
    applyStimulus(0, 1, 1, 0, 0, 0, 1);
    applyStimulus(0, 1, 1, 0, 0, 0, 1);
    checkOutput("rst_PC_D", pc_d, 32'h0);
    checkOutput("rst_Instr_D", instr_d, NOP);
    checkOutput("rst_addr", imem_addr, 32'h0);

    $display("[TB] zero-wait stream");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 1, 0, 0, 0, 1);
      checkOutput("zw_PC_D", pc_d, 32'(i * 4));
      checkOutput("zw_Instr_D", instr_d, 32'(i * 4) ^ KEY);
    end

    $display("[TB] memory wait at 0x10");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 1, 0, 0, 0, 0);
      checkOutput("wait_addr", imem_addr, 32'h10);
      checkOutput("wait_valid", {31'b0, valid_d}, 32'h0);
    end
    applyStimulus(1, 1, 1, 0, 0, 0, 1);
    checkOutput("wait_PC_D", pc_d, 32'h10);

    $display("[TB] skid buffer at 0x20");
    applyStimulus(1, 1, 1, 0, 1, 32'h20, 1);
    checkOutput("skid_addr", imem_addr, 32'h20);
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    checkOutput("skid_req", {31'b0, imem_req}, 32'h0);
    applyStimulus(1, 1, 1, 0, 0, 0, 0);
    checkOutput("skid_PC_D", pc_d, 32'h20);
    checkOutput("skid_next_addr", imem_addr, 32'h24);
    applyStimulus(1, 1, 1, 0, 0, 0, 1);
    checkOutput("skid_after_PC_D", pc_d, 32'h24);

    $display("[TB] redirect during outstanding request");
    applyStimulus(1, 1, 1, 0, 1, 32'h40, 1);
    applyStimulus(1, 1, 1, 0, 1, 32'h103, 0);
    checkOutput("disc_addr_hold", imem_addr, 32'h40);
    applyStimulus(1, 1, 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 0, 1);
    checkOutput("disc_addr", imem_addr, 32'h100);
    checkOutput("disc_valid", {31'b0, valid_d}, 32'h0);
    applyStimulus(1, 1, 1, 0, 0, 0, 1);
    checkOutput("disc_PC_D", pc_d, 32'h100);
    checkOutput("disc_Instr_D", instr_d, 32'h100 ^ KEY);

    $display("[TB] PC wrap");
    applyStimulus(1, 1, 1, 0, 1, 32'hFFFF_FFFC, 1);
    applyStimulus(1, 1, 1, 0, 0, 0, 1);
    checkOutput("wrap_PC_D", pc_d, 32'hFFFF_FFFC);
    checkOutput("wrap_PCPlus4_D", pcplus4_d, 32'h0);
    checkOutput("wrap_addr", imem_addr, 32'h0);

    $display("[TB] flush while decode stalled");
    applyStimulus(1, 0, 0, 1, 0, 0, 1);
    checkOutput("flush_valid", {31'b0, valid_d}, 32'h0);
    checkOutput("flush_instr", instr_d, NOP);
    checkOutput("flush_addr", imem_addr, 32'h0);

    $display("[TB] reset mid-wait");
    applyStimulus(1, 1, 1, 0, 0, 0, 1);
    applyStimulus(1, 1, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0, 0);
    checkOutput("midrst_valid", {31'b0, valid_d}, 32'h0);
    checkOutput("midrst_instr", instr_d, NOP);
    checkOutput("midrst_addr", imem_addr, 32'h0);
    applyStimulus(1, 1, 1, 0, 0, 0, 1);
    checkOutput("midrst_PC_D", pc_d, 32'h0);
    checkOutput("midrst_accept", {31'b0, valid_d}, 32'h1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      bit sd;
      bit sf;
      sd = ($urandom_range(3, 0) != 0);
      sf = ($urandom_range(7, 0) != 0) ? sd : 1'($urandom_range(1, 0));
      applyStimulus(($urandom_range(63, 0) != 0), sf, sd,
                    ($urandom_range(9, 0) == 0), ($urandom_range(11, 0) == 0),
                    $urandom(), 1'($urandom_range(1, 0)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
